// File: rtl/chi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chi_link_ctrl
// Description : CHI link-layer controller with independent TX/RX activation
//               FSMs, per-channel L-credit tracking and sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module chi_link_ctrl #(
    parameter int NUM_TX_CHN = 3,
    parameter int NUM_RX_CHN = 3,
    parameter int MAX_LCRD   = 15,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  tx_link_en,
    input  logic                  rx_link_en,
    output logic                  CHI_TXLINKACTIVEREQ,
    input  logic                  CHI_TXLINKACTIVEACK,
    input  logic                  CHI_RXLINKACTIVEREQ,
    output logic                  CHI_RXLINKACTIVEACK,
    input  logic [NUM_TX_CHN-1:0] tx_lcrdv,
    input  logic [NUM_TX_CHN-1:0] tx_flitv,
    output logic [NUM_TX_CHN-1:0] tx_crd_avail,
    output logic [NUM_TX_CHN-1:0] tx_crd_rtn_pend,
    input  logic [NUM_RX_CHN-1:0] rx_flitv,
    input  logic [NUM_RX_CHN-1:0] rx_buf_rdy,
    output logic [NUM_RX_CHN-1:0] rx_lcrdv,
    output logic [1:0]            tx_state,
    output logic [1:0]            rx_state,
    output logic [3:0]            err_sticky,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        ST_STOP       = 2'd0,
        ST_ACTIVATE   = 2'd1,
        ST_RUN        = 2'd2,
        ST_DEACTIVATE = 2'd3
    } link_state_t;

    localparam logic [CNT_W-1:0] C_MAX_LCRD = CNT_W'(MAX_LCRD);

    link_state_t           r_tx_state, w_tx_state_nxt;
    link_state_t           r_rx_state, w_rx_state_nxt;
    logic                  r_tx_req;
    logic                  r_rx_ack;
    logic                  w_tx_cnt_en;
    logic [NUM_TX_CHN-1:0] w_tx_nz, w_tx_ovf, w_tx_unf, w_tx_stop_crd;
    logic [NUM_RX_CHN-1:0] w_rx_nz, w_rx_unexp;
    logic [3:0]            r_err, w_err_set;

    assign w_tx_cnt_en = (r_tx_state != ST_STOP);

    // ---------------- TX link FSM ----------------
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            ST_STOP:       if (tx_link_en && !CHI_TXLINKACTIVEACK) w_tx_state_nxt = ST_ACTIVATE;
            ST_ACTIVATE:   if (CHI_TXLINKACTIVEACK)                w_tx_state_nxt = ST_RUN;
            ST_RUN:        if (!tx_link_en)                        w_tx_state_nxt = ST_DEACTIVATE;
            ST_DEACTIVATE: if (!CHI_TXLINKACTIVEACK && !(|w_tx_nz)) w_tx_state_nxt = ST_STOP;
            default:       w_tx_state_nxt = ST_STOP;
        endcase
    end

    // REQ is registered from the next state so it always tracks tx_state exactly
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tx_state <= ST_STOP;
            r_tx_req   <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_req   <= (w_tx_state_nxt == ST_ACTIVATE) || (w_tx_state_nxt == ST_RUN);
        end
    end

    // ---------------- TX credit counters ----------------
    for (genvar gi = 0; gi < NUM_TX_CHN; gi++) begin : g_tx_chn
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc             = w_tx_cnt_en && tx_lcrdv[gi] && !tx_flitv[gi];
        assign w_dec             = w_tx_cnt_en && tx_flitv[gi] && !tx_lcrdv[gi];
        assign w_tx_nz[gi]       = (r_cnt != '0);
        assign w_tx_ovf[gi]      = w_inc && (r_cnt == C_MAX_LCRD);
        assign w_tx_unf[gi]      = w_dec && (r_cnt == '0);
        assign w_tx_stop_crd[gi] = !w_tx_cnt_en && tx_lcrdv[gi];

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_cnt <= '0;
            end else if (w_inc && !w_tx_ovf[gi]) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_tx_unf[gi]) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // ---------------- RX link FSM ----------------
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            ST_STOP:       if (CHI_RXLINKACTIVEREQ && rx_link_en) w_rx_state_nxt = ST_ACTIVATE;
            ST_ACTIVATE:   w_rx_state_nxt = ST_RUN;
            ST_RUN:        if (!CHI_RXLINKACTIVEREQ)              w_rx_state_nxt = ST_DEACTIVATE;
            ST_DEACTIVATE: if (!(|w_rx_nz))                       w_rx_state_nxt = ST_STOP;
            default:       w_rx_state_nxt = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rx_state <= ST_STOP;
            r_rx_ack   <= 1'b0;
        end else begin
            r_rx_state <= w_rx_state_nxt;
            r_rx_ack   <= (w_rx_state_nxt == ST_RUN) || (w_rx_state_nxt == ST_DEACTIVATE);
        end
    end

    // ---------------- RX credit issue / outstanding tracking ----------------
    for (genvar gi = 0; gi < NUM_RX_CHN; gi++) begin : g_rx_chn
        logic [CNT_W-1:0] r_g;
        logic             r_lcrdv;
        logic             w_issue;

        assign w_issue         = (r_rx_state == ST_RUN) && (r_g != C_MAX_LCRD) && rx_buf_rdy[gi];
        assign w_rx_nz[gi]     = (r_g != '0);
        assign w_rx_unexp[gi]  = rx_flitv[gi] && !w_issue && ((r_g == '0) || (r_rx_state == ST_STOP));
        assign rx_lcrdv[gi]    = r_lcrdv;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_g     <= '0;
                r_lcrdv <= 1'b0;
            end else begin
                r_lcrdv <= w_issue;
                if (w_issue && !rx_flitv[gi]) begin
                    r_g <= r_g + CNT_W'(1);
                end else if (!w_issue && rx_flitv[gi] && (r_g != '0)) begin
                    r_g <= r_g - CNT_W'(1);
                end
            end
        end
    end

    // ---------------- Sticky errors: a new event outranks a clear ----------------
    assign w_err_set = {|w_tx_stop_crd, |w_rx_unexp, |w_tx_unf, |w_tx_ovf};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_err <= 4'b0000;
        end else begin
            r_err <= (err_clr ? 4'b0000 : r_err) | w_err_set;
        end
    end

    assign CHI_TXLINKACTIVEREQ = r_tx_req;
    assign CHI_RXLINKACTIVEACK = r_rx_ack;
    assign tx_crd_avail        = (r_tx_state == ST_RUN)        ? w_tx_nz : '0;
    assign tx_crd_rtn_pend     = (r_tx_state == ST_DEACTIVATE) ? w_tx_nz : '0;
    assign tx_state            = r_tx_state;
    assign rx_state            = r_rx_state;
    assign err_sticky          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_chi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_chi_link_ctrl
// Description : Directed self-checking bench for chi_link_ctrl (3 TX / 3 RX).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chi_link_ctrl;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_link_en = 1'b0, rx_link_en = 1'b0;
    logic       txack = 1'b0, rxreq = 1'b0, err_clr = 1'b0;
    logic [2:0] tx_lcrdv = '0, tx_flitv = '0, rx_flitv = '0, rx_buf_rdy = '0;
    logic       txreq, rxack;
    logic [2:0] tx_crd_avail, tx_crd_rtn_pend, rx_lcrdv;
    logic [1:0] tx_state, rx_state;
    logic [3:0] err_sticky;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chi_link_ctrl #(
        .NUM_TX_CHN(3), .NUM_RX_CHN(3), .MAX_LCRD(15), .CNT_W(4)
    ) dut (
        .clk(clk), .resetn(resetn),
        .tx_link_en(tx_link_en), .rx_link_en(rx_link_en),
        .CHI_TXLINKACTIVEREQ(txreq), .CHI_TXLINKACTIVEACK(txack),
        .CHI_RXLINKACTIVEREQ(rxreq), .CHI_RXLINKACTIVEACK(rxack),
        .tx_lcrdv(tx_lcrdv), .tx_flitv(tx_flitv),
        .tx_crd_avail(tx_crd_avail), .tx_crd_rtn_pend(tx_crd_rtn_pend),
        .rx_flitv(rx_flitv), .rx_buf_rdy(rx_buf_rdy), .rx_lcrdv(rx_lcrdv),
        .tx_state(tx_state), .rx_state(rx_state),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    typedef struct packed {
        logic       en;
        logic       ack;
        logic [2:0] l;
        logic [2:0] f;
        logic       clr;
        logic [1:0] e_st;
        logic       e_req;
        logic [2:0] e_av;
        logic [2:0] e_rtn;
        logic [3:0] e_err;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic i_en, input logic i_ack, input logic [2:0] i_l,
                       input logic [2:0] i_f, input logic i_clr, input logic i_rreq,
                       input logic i_ren, input logic [2:0] i_rf, input logic [2:0] i_rdy);
        tx_link_en = i_en;  txack = i_ack;  tx_lcrdv = i_l;  tx_flitv = i_f;
        err_clr = i_clr;    rxreq = i_rreq; rx_link_en = i_ren;
        rx_flitv = i_rf;    rx_buf_rdy = i_rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic tx_cyc(input logic i_en, input logic i_ack, input logic [2:0] i_l,
                          input logic [2:0] i_f, input logic i_clr);
        cyc(i_en, i_ack, i_l, i_f, i_clr, 1'b0, 1'b0, 3'b000, 3'b000);
    endtask

    task automatic rx_cyc(input logic i_rreq, input logic i_ren, input logic [2:0] i_rf,
                          input logic [2:0] i_rdy);
        cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, i_rreq, i_ren, i_rf, i_rdy);
    endtask

    function automatic logic [18:0] all_outs();
        return {txreq, rxack, tx_crd_avail, tx_crd_rtn_pend, rx_lcrdv,
                tx_state, rx_state, err_sticky};
    endfunction

    initial begin
        // en ack lcrdv flitv clr | st req avail rtn err
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 2'd1, 1'b1, 3'd0, 3'd0, 4'd0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 2'd1, 1'b1, 3'd0, 3'd0, 4'd0};
        tbl[2]  = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 2'd2, 1'b1, 3'd0, 3'd0, 4'd0};
        tbl[3]  = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b0, 2'd2, 1'b1, 3'd0, 3'd0, 4'd0};
        for (int i = 4; i < 9; i++)
            tbl[i] = '{1'b1, 1'b1, 3'd1, 3'd0, 1'b0, 2'd2, 1'b1, 3'd1, 3'd0, 4'd0};
        tbl[9]  = '{1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 2'd2, 1'b1, 3'd7, 3'd0, 4'd0};
        tbl[10] = '{1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 2'd2, 1'b1, 3'd5, 3'd0, 4'd0};
        tbl[11] = '{1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 2'd2, 1'b1, 3'd5, 3'd0, 4'd2};
        tbl[12] = '{1'b1, 1'b1, 3'd0, 3'd0, 1'b1, 2'd2, 1'b1, 3'd5, 3'd0, 4'd0};
        tbl[13] = '{1'b1, 1'b1, 3'd1, 3'd1, 1'b0, 2'd2, 1'b1, 3'd5, 3'd0, 4'd0};
        tbl[14] = '{1'b1, 1'b1, 3'd0, 3'd4, 1'b0, 2'd2, 1'b1, 3'd1, 3'd0, 4'd0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", 32'(all_outs()), 32'd0);
        resetn = 1'b1;

        // TX bring-up and credit accounting
        for (int i = 0; i < 15; i++) begin
            tx_cyc(tbl[i].en, tbl[i].ack, tbl[i].l, tbl[i].f, tbl[i].clr);
            chk($sformatf("tbl%0d.tx_state", i), 32'(tx_state), 32'(tbl[i].e_st));
            chk($sformatf("tbl%0d.txreq", i), 32'(txreq), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d.avail", i), 32'(tx_crd_avail), 32'(tbl[i].e_av));
            chk($sformatf("tbl%0d.rtn", i), 32'(tx_crd_rtn_pend), 32'(tbl[i].e_rtn));
            chk($sformatf("tbl%0d.err", i), 32'(err_sticky), 32'(tbl[i].e_err));
        end

        // ch0 at 5: fill to 15, then saturation behaviour
        for (int k = 0; k < 10; k++) tx_cyc(1'b1, 1'b1, 3'b001, 3'b000, 1'b0);
        chk("fill15.err", 32'(err_sticky), 32'd0);
        tx_cyc(1'b1, 1'b1, 3'b001, 3'b000, 1'b0);
        chk("ovf.err", 32'(err_sticky), 32'h1);
        tx_cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b1);
        chk("ovf_clr.err", 32'(err_sticky), 32'h0);
        tx_cyc(1'b1, 1'b1, 3'b001, 3'b001, 1'b0);
        chk("both_at_max.err", 32'(err_sticky), 32'h0);
        tx_cyc(1'b1, 1'b1, 3'b001, 3'b000, 1'b0);
        chk("still15.err", 32'(err_sticky), 32'h1);
        tx_cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b1);
        for (int k = 0; k < 12; k++) tx_cyc(1'b1, 1'b1, 3'b000, 3'b001, 1'b0);
        chk("cnt3.avail", 32'(tx_crd_avail), 32'h1);
        chk("cnt3.err", 32'(err_sticky), 32'h0);

        // Deactivate with 3 credits held on ch0
        tx_cyc(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
        chk("deact.state", 32'(tx_state), 32'd3);
        chk("deact.req", 32'(txreq), 32'd0);
        chk("deact.avail", 32'(tx_crd_avail), 32'd0);
        chk("deact.rtn", 32'(tx_crd_rtn_pend), 32'h1);
        tx_cyc(1'b0, 1'b1, 3'b000, 3'b001, 1'b0);
        chk("rtn1.rtn", 32'(tx_crd_rtn_pend), 32'h1);
        tx_cyc(1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
        chk("rtn2.state", 32'(tx_state), 32'd3);
        tx_cyc(1'b0, 1'b0, 3'b000, 3'b001, 1'b0);
        chk("rtn3.rtn", 32'(tx_crd_rtn_pend), 32'h0);
        chk("rtn3.state", 32'(tx_state), 32'd3);
        tx_cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("stop.state", 32'(tx_state), 32'd0);
        chk("stop.req", 32'(txreq), 32'd0);
        tx_cyc(1'b0, 1'b0, 3'b010, 3'b000, 1'b0);
        chk("stop_crd.err", 32'(err_sticky), 32'h8);
        tx_cyc(1'b0, 1'b0, 3'b010, 3'b000, 1'b1);
        chk("set_wins.err", 32'(err_sticky), 32'h8);
        tx_cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);
        chk("clr.err", 32'(err_sticky), 32'h0);

        // RX activation and credit issue
        rx_cyc(1'b1, 1'b1, 3'b000, 3'b111);
        chk("rx_act.state", 32'(rx_state), 32'd1);
        chk("rx_act.ack", 32'(rxack), 32'd0);
        rx_cyc(1'b1, 1'b1, 3'b000, 3'b111);
        chk("rx_run.state", 32'(rx_state), 32'd2);
        chk("rx_run.ack", 32'(rxack), 32'd1);
        chk("rx_run.lcrdv", 32'(rx_lcrdv), 32'd0);
        for (int k = 0; k < 15; k++) begin
            rx_cyc(1'b1, 1'b1, 3'b000, 3'b111);
            chk($sformatf("rx_issue%0d", k), 32'(rx_lcrdv), 32'h7);
        end
        rx_cyc(1'b1, 1'b1, 3'b000, 3'b111);
        chk("rx_sat0.lcrdv", 32'(rx_lcrdv), 32'h0);
        rx_cyc(1'b1, 1'b1, 3'b000, 3'b111);
        chk("rx_sat1.lcrdv", 32'(rx_lcrdv), 32'h0);
        for (int k = 0; k < 13; k++) rx_cyc(1'b1, 1'b1, 3'b111, 3'b000);
        chk("rx_g2.err", 32'(err_sticky), 32'h0);
        chk("rx_g2.lcrdv", 32'(rx_lcrdv), 32'h0);

        // RX deactivation with 2 outstanding per channel
        rx_cyc(1'b0, 1'b1, 3'b000, 3'b000);
        chk("rx_deact.state", 32'(rx_state), 32'd3);
        chk("rx_deact.ack", 32'(rxack), 32'd1);
        rx_cyc(1'b0, 1'b1, 3'b000, 3'b111);
        chk("rx_deact.no_issue", 32'(rx_lcrdv), 32'h0);
        rx_cyc(1'b0, 1'b1, 3'b111, 3'b111);
        chk("rx_g1.state", 32'(rx_state), 32'd3);
        rx_cyc(1'b0, 1'b1, 3'b111, 3'b111);
        chk("rx_g0.state", 32'(rx_state), 32'd3);
        chk("rx_g0.lcrdv", 32'(rx_lcrdv), 32'h0);
        rx_cyc(1'b0, 1'b1, 3'b000, 3'b111);
        chk("rx_stop.state", 32'(rx_state), 32'd0);
        chk("rx_stop.ack", 32'(rxack), 32'd0);
        rx_cyc(1'b0, 1'b1, 3'b001, 3'b111);
        chk("rx_unexp.err", 32'(err_sticky), 32'h4);
        tx_cyc(1'b0, 1'b0, 3'b000, 3'b000, 1'b1);

        // Reset mid-operation: TX RUN with 7 credits, RX RUN
        tx_cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
        tx_cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
        for (int k = 0; k < 7; k++) tx_cyc(1'b1, 1'b1, 3'b001, 3'b000, 1'b0);
        cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 3'b111);
        cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 3'b111);
        chk("pre_rst.rx_state", 32'(rx_state), 32'd2);
        chk("pre_rst.avail", 32'(tx_crd_avail), 32'h1);
        cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 3'b000, 3'b111);
        resetn = 1'b0;
        #1;
        chk("rst_async.outs", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_held.outs", 32'(all_outs()), 32'd0);
        resetn = 1'b1;
        tx_cyc(1'b1, 1'b0, 3'b000, 3'b000, 1'b0);
        chk("post_rst.tx_state", 32'(tx_state), 32'd1);
        chk("post_rst.rx_state", 32'(rx_state), 32'd0);
        tx_cyc(1'b1, 1'b1, 3'b000, 3'b000, 1'b0);
        chk("post_rst.run", 32'(tx_state), 32'd2);
        chk("post_rst.cnt0", 32'(tx_crd_avail), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/chi_link_ctrl.md
Name: chi_link_ctrl

Overview:
- Parametrised CHI link-layer controller for the CHI bridge family (HN-F and RN-F tops).
- Runs independent TX and RX link-activation state machines.
- Tracks L-credits per TX channel and issues L-credits per RX channel, with channel counts and credit depth set by parameters.
- Adds credit-return handling on deactivation and sticky protocol-error flags.

Parameters:
- NUM_TX_CHN, 3, number of TX channels (1..4); bit i of each TX vector is channel i.
- NUM_RX_CHN, 3, number of RX channels (1..4).
- MAX_LCRD, 15, maximum L-credits per channel (1..15).
- CNT_W, 4, credit counter width; must be >= clog2(MAX_LCRD+1).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- tx_link_en  in  1  software request to bring the TX link up (1) or down (0)
- rx_link_en  in  1  permits the RX link to activate
- CHI_TXLINKACTIVEREQ  out  1  TX link request
- CHI_TXLINKACTIVEACK  in  1  TX link acknowledge from remote
- CHI_RXLINKACTIVEREQ  in  1  RX link request from remote
- CHI_RXLINKACTIVEACK  out  1  RX link acknowledge
- tx_lcrdv  in  NUM_TX_CHN  per-channel credit grant pulse from remote
- tx_flitv  in  NUM_TX_CHN  per-channel flit sent (consumes one credit)
- tx_crd_avail  out  NUM_TX_CHN  channel may send a protocol flit
- tx_crd_rtn_pend  out  NUM_TX_CHN  channel must send credit-return flits
- rx_flitv  in  NUM_RX_CHN  per-channel flit received
- rx_buf_rdy  in  NUM_RX_CHN  downstream buffer can absorb one more flit
- rx_lcrdv  out  NUM_RX_CHN  per-channel credit grant pulse to remote
- tx_state  out  2  TX FSM state
- rx_state  out  2  RX FSM state
- err_sticky  out  4  [0] TX overflow, [1] TX underflow, [2] RX unexpected flit, [3] credit received in TX STOP
- err_clr  in  1  clears err_sticky

Behaviour:
- State encoding, both FSMs: STOP=0, ACTIVATE=1, RUN=2, DEACTIVATE=3.
- Reset values: all outputs 0, both FSMs in STOP, all counters 0.
- TX FSM, CHI_TXLINKACTIVEREQ registered (1 in ACTIVATE and RUN, 0 otherwise):
  - STOP: tx_link_en=1 and ACK=0 -> ACTIVATE.
  - ACTIVATE: ACK=1 -> RUN.
  - RUN: tx_link_en=0 -> DEACTIVATE.
  - DEACTIVATE: ACK=0 and all TX counts 0 -> STOP.
- TX credit count, per channel:
  - lcrdv alone: +1. flitv alone: -1. Both in the same cycle: unchanged.
  - lcrdv at MAX_LCRD: count saturates, err[0] set.
  - flitv at count 0: count stays 0, err[1] set.
  - lcrdv in STOP: ignored, err[3] set.
  - Counting is active in ACTIVATE, RUN and DEACTIVATE.
- tx_crd_avail[i] = (tx_state==RUN) && count!=0; combinational from registered state.
- tx_crd_rtn_pend[i] = (tx_state==DEACTIVATE) && count!=0. Upstream sends return flits on tx_flitv; each one decrements the count.
- RX FSM, CHI_RXLINKACTIVEACK registered (1 in RUN and DEACTIVATE, 0 otherwise):
  - STOP: REQ=1 and rx_link_en=1 -> ACTIVATE.
  - ACTIVATE: unconditional -> RUN after exactly 1 cycle, so ACK rises 2 cycles after REQ is sampled.
  - RUN: REQ=0 -> DEACTIVATE.
  - DEACTIVATE: all RX outstanding counts 0 -> STOP.
- RX outstanding count g[i]:
  - rx_lcrdv[i] is a registered 1-cycle pulse, issued when rx_state==RUN, g[i]<MAX_LCRD and rx_buf_rdy[i]=1. At most one per channel per cycle; back-to-back issue is allowed.
  - Issue: +1. rx_flitv: -1. Both in the same cycle: unchanged.
  - rx_flitv with g=0, or in STOP: g stays 0, err[2] set.
  - No credits are issued in ACTIVATE or DEACTIVATE.
- err_sticky bits are set on the error event. err_clr clears them; if a set event and err_clr coincide, set wins.
- Reset asserted mid-operation: every output immediately returns to its reset value; no credit-return sequence runs.

Test Plan:
- Reset, then tx_link_en=1, remote ACK rises 3 cycles later -> tx_state 0->1->2; tx_crd_avail=0 until first tx_lcrdv; 5 lcrdv pulses -> count=5, tx_crd_avail=1.
- RUN with count=15: tx_lcrdv -> count stays 15, err_sticky=4'b0001. Then err_clr -> 4'b0000. Then lcrdv and flitv in the same cycle -> count stays 15.
- tx_link_en=0 with count=3 -> DEACTIVATE, tx_crd_rtn_pend=1, tx_crd_avail=0; 3 tx_flitv and ACK=0 -> STOP, REQ=0.
- Remote REQ=1, rx_link_en=1, rx_buf_rdy=all 1 -> ACK at +2 cycles; 15 rx_lcrdv pulses per channel on consecutive cycles, then none (g=15).
- RX RUN with g=2: REQ=0 -> no further rx_lcrdv; 2 rx_flitv -> STOP, ACK=0; an extra rx_flitv in STOP -> err[2]=1.
- Reset asserted with TX RUN count=7 and RX RUN -> all outputs 0 on the next cycle; after release, state=STOP and counts=0.
